// File: rtl/ex_mem_pipeline_stage_if.sv
// Signal bundle for the EX/MEM slice: ID-stage inputs, the registered EX/MEM
// copies, the port A read data and the host-side port B of the data memory.
interface ex_mem_pipeline_stage_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_wreg_en;
  logic                      id_wmem_en;
  logic [DATA_WIDTH-1:0]     id_r1out;
  logic [DATA_WIDTH-1:0]     id_r2out;
  logic [REG_ADDR_WIDTH-1:0] id_wreg1;

  logic                      ex_wreg_en;
  logic                      ex_wmem_en;
  logic [DATA_WIDTH-1:0]     ex_r1out;
  logic [DATA_WIDTH-1:0]     ex_r2out;
  logic [REG_ADDR_WIDTH-1:0] ex_wreg1;

  logic                      mem_wreg_en;
  logic                      mem_wmem_en;
  logic [DATA_WIDTH-1:0]     mem_r1out;
  logic [DATA_WIDTH-1:0]     mem_r2out;
  logic [REG_ADDR_WIDTH-1:0] mem_wreg1;
  logic [DATA_WIDTH-1:0]     mem_dout;

  logic [ADDR_WIDTH-1:0]     addrb;
  logic [DATA_WIDTH-1:0]     dinb;
  logic                      web;
  logic [DATA_WIDTH-1:0]     doutb;

  modport master (
    output id_wreg_en, id_wmem_en, id_r1out, id_r2out, id_wreg1,
    output addrb, dinb, web,
    input  ex_wreg_en, ex_wmem_en, ex_r1out, ex_r2out, ex_wreg1,
    input  mem_wreg_en, mem_wmem_en, mem_r1out, mem_r2out, mem_wreg1,
    input  mem_dout, doutb
  );

  modport slave (
    input  id_wreg_en, id_wmem_en, id_r1out, id_r2out, id_wreg1,
    input  addrb, dinb, web,
    output ex_wreg_en, ex_wmem_en, ex_r1out, ex_r2out, ex_wreg1,
    output mem_wreg_en, mem_wmem_en, mem_r1out, mem_r2out, mem_wreg1,
    output mem_dout, doutb
  );
endinterface

// File: rtl/ex_mem_pipeline_stage.sv
// ID/EX and EX/MEM pipeline registers feeding port A of a true dual-port
// write-first data memory; port B is a host access port.
module ex_mem_pipeline_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic                     clk,
  input logic                     reset,
  ex_mem_pipeline_stage_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic                      wreg_en;
    logic                      wmem_en;
    logic [DATA_WIDTH-1:0]     r1out;
    logic [DATA_WIDTH-1:0]     r2out;
    logic [REG_ADDR_WIDTH-1:0] wreg1;
  } stage_t;

  stage_t ex_d, ex_q;
  stage_t mem_d, mem_q;

  always_comb begin
    ex_d         = '0;
    ex_d.wreg_en = bus.id_wreg_en;
    ex_d.wmem_en = bus.id_wmem_en;
    ex_d.r1out   = bus.id_r1out;
    ex_d.r2out   = bus.id_r2out;
    ex_d.wreg1   = bus.id_wreg1;
    mem_d        = ex_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  assign bus.ex_wreg_en  = ex_q.wreg_en;
  assign bus.ex_wmem_en  = ex_q.wmem_en;
  assign bus.ex_r1out    = ex_q.r1out;
  assign bus.ex_r2out    = ex_q.r2out;
  assign bus.ex_wreg1    = ex_q.wreg1;
  assign bus.mem_wreg_en = mem_q.wreg_en;
  assign bus.mem_wmem_en = mem_q.wmem_en;
  assign bus.mem_r1out   = mem_q.r1out;
  assign bus.mem_r2out   = mem_q.r2out;
  assign bus.mem_wreg1   = mem_q.wreg1;

  // Port A is fed straight from the EX/MEM register; upper address bits wrap.
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  wea;

  always_comb begin
    addra = mem_q.r1out[ADDR_WIDTH-1:0];
    dina  = mem_q.r2out;
    wea   = mem_q.wmem_en;
  end

  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1] = '{default: '0};
  logic [DATA_WIDTH-1:0] douta_q = '0;
  logic [DATA_WIDTH-1:0] doutb_q = '0;

  // Memory and read registers ignore reset so a store already at port A
  // completes. Port A's write is issued last so it wins a same-address clash;
  // a cross-port read sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (bus.web) begin
      ram[bus.addrb] <= bus.dinb;
      doutb_q        <= bus.dinb;
    end else begin
      doutb_q        <= ram[bus.addrb];
    end
    if (wea) begin
      ram[addra] <= dina;
      douta_q    <= dina;
    end else begin
      douta_q    <= ram[addra];
    end
  end

  assign bus.mem_dout = douta_q;
  assign bus.doutb    = doutb_q;
endmodule

// File: tb/tb_ex_mem_pipeline_stage.sv
// Directed bench for ex_mem_pipeline_stage: latency, store/load, host access,
// cross-port collisions and reset flush, with hand-computed expectations.
module tb_ex_mem_pipeline_stage;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  ex_mem_pipeline_stage_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .REG_ADDR_WIDTH(5)) bus ();

  ex_mem_pipeline_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .REG_ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-22s got=%h", tag, got);
    end else begin
      $display("FAIL %-22s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic wreg_en, input logic wmem_en, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [4:0] wreg1);
    bus.id_wreg_en = wreg_en;
    bus.id_wmem_en = wmem_en;
    bus.id_r1out   = r1;
    bus.id_r2out   = r2;
    bus.id_wreg1   = wreg1;
  endtask

  task automatic drive_b(input logic we, input logic [7:0] addr, input logic [63:0] din);
    bus.web   = we;
    bus.addrb = addr;
    bus.dinb  = din;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    drive_id(1'b1, 1'b1, 64'h0000_0000_0000_0077, 64'h1234, 5'd31);
    drive_b(1'b0, 8'h00, 64'h0);

    // Reset with busy ID inputs
    tick();
    tick();
    check("rst ex_wreg_en",  {63'b0, bus.ex_wreg_en},  64'h0);
    check("rst ex_wmem_en",  {63'b0, bus.ex_wmem_en},  64'h0);
    check("rst ex_r1out",    bus.ex_r1out,             64'h0);
    check("rst ex_wreg1",    {59'b0, bus.ex_wreg1},    64'h0);
    check("rst mem_wmem_en", {63'b0, bus.mem_wmem_en}, 64'h0);
    check("rst mem_r2out",   bus.mem_r2out,            64'h0);
    drive_id(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    reset = 1'b0;
    tick();

    // Pipeline latency
    drive_id(1'b1, 1'b0, 64'hA, 64'hB, 5'd3);
    tick();
    check("lat ex_wreg_en",  {63'b0, bus.ex_wreg_en},  64'h1);
    check("lat ex_wreg1",    {59'b0, bus.ex_wreg1},    64'h3);
    check("lat ex_r1out",    bus.ex_r1out,             64'hA);
    check("lat ex_r2out",    bus.ex_r2out,             64'hB);
    check("lat mem_wreg_en", {63'b0, bus.mem_wreg_en}, 64'h0);
    drive_id(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    tick();
    check("lat mem_wreg_en", {63'b0, bus.mem_wreg_en}, 64'h1);
    check("lat mem_wreg1",   {59'b0, bus.mem_wreg1},   64'h3);
    check("lat mem_r1out",   bus.mem_r1out,            64'hA);
    check("lat mem_r2out",   bus.mem_r2out,            64'hB);
    check("lat ex cleared",  bus.ex_r1out,             64'h0);
    tick();
    check("lat mem cleared", bus.mem_r1out,            64'h0);

    // Store through port A at 0x110 (wraps to 0x10), then load
    drive_id(1'b0, 1'b1, 64'h0000_0000_0000_0110, 64'hDEAD_BEEF_0123_4567, 5'd0);
    tick();
    drive_id(1'b0, 1'b0, 64'h0000_0000_0000_0110, 64'h0, 5'd0);
    tick();
    check("st mem_wmem_en", {63'b0, bus.mem_wmem_en}, 64'h1);
    drive_id(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    tick();
    check("st write-first", bus.mem_dout, 64'hDEAD_BEEF_0123_4567);
    drive_b(1'b0, 8'h10, 64'h0);
    tick();
    check("ld mem_dout",    bus.mem_dout, 64'hDEAD_BEEF_0123_4567);
    check("ld doutb 0x10",  bus.doutb,    64'hDEAD_BEEF_0123_4567);
    tick();

    // Host write at 0x05, pipeline read
    drive_b(1'b1, 8'h05, 64'h1122_3344_5566_7788);
    tick();
    check("hw doutb wf", bus.doutb, 64'h1122_3344_5566_7788);
    drive_b(1'b0, 8'h00, 64'h0);
    drive_id(1'b0, 1'b0, 64'h5, 64'h0, 5'd0);
    tick();
    drive_id(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    tick();
    tick();
    check("hw pipe read", bus.mem_dout, 64'h1122_3344_5566_7788);

    // Cross-port: A writes 0x20 while B reads it
    drive_b(1'b1, 8'h20, 64'h0);
    tick();
    drive_b(1'b0, 8'h20, 64'h0);
    drive_id(1'b0, 1'b1, 64'h20, 64'hAAAA, 5'd0);
    tick();
    drive_id(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    tick();
    tick();
    check("xp A wf",       bus.mem_dout, 64'hAAAA);
    check("xp B old data", bus.doutb,    64'h0);
    tick();
    check("xp B new data", bus.doutb,    64'hAAAA);

    // Both ports write 0x20 on the same edge
    drive_id(1'b0, 1'b1, 64'h20, 64'h1, 5'd0);
    tick();
    drive_id(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    tick();
    drive_b(1'b1, 8'h20, 64'h2);
    tick();
    check("ww A wf",      bus.mem_dout, 64'h1);
    check("ww B wf",      bus.doutb,    64'h2);
    drive_b(1'b0, 8'h20, 64'h0);
    tick();
    check("ww A wins",    bus.doutb,    64'h1);

    // Reset flush: store to 0x30 discarded while in ID/EX
    drive_id(1'b0, 1'b1, 64'h30, 64'h55, 5'd0);
    tick();
    drive_id(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    reset = 1'b1;
    tick();
    check("fl ex_wmem_en",  {63'b0, bus.ex_wmem_en},  64'h0);
    check("fl mem_wmem_en", {63'b0, bus.mem_wmem_en}, 64'h0);
    reset = 1'b0;
    tick();
    tick();
    tick();
    drive_b(1'b0, 8'h30, 64'h0);
    tick();
    check("fl 0x30 zero",   bus.doutb, 64'h0);
    drive_b(1'b0, 8'h10, 64'h0);
    tick();
    check("fl 0x10 kept",   bus.doutb, 64'hDEAD_BEEF_0123_4567);

    // A store already at port A when reset arrives still lands
    drive_id(1'b0, 1'b1, 64'h40, 64'h77, 5'd0);
    tick();
    drive_id(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_b(1'b0, 8'h40, 64'h0);
    tick();
    check("rs 0x40 written", bus.doutb, 64'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipeline_stage.md
Name: ex_mem_pipeline_stage

Overview:
- Execute/memory slice of the 5-stage packet-processor pipeline.
- Chains two pipeline registers (ID/EX, then EX/MEM) in front of a 256 x 64-bit true dual-port data memory.
- Port A is driven by the pipeline: address from operand 1, write data from operand 2.
- Port B is a host/software access port, exposed through the register interface.

Parameters:
- DATA_WIDTH, 64, operand and memory word width.
- ADDR_WIDTH, 8, memory address width; depth = 2^ADDR_WIDTH words.
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears both pipeline registers.
- id_wreg_en  in  1  ID-stage register-write enable.
- id_wmem_en  in  1  ID-stage memory-write enable.
- id_r1out  in  DATA_WIDTH  ID operand 1; its low ADDR_WIDTH bits are the memory address.
- id_r2out  in  DATA_WIDTH  ID operand 2; this is the store data.
- id_wreg1  in  REG_ADDR_WIDTH  ID destination register.
- ex_wreg_en, ex_wmem_en  out  1 each  EX-stage registered copies.
- ex_r1out, ex_r2out  out  DATA_WIDTH  EX-stage operands.
- ex_wreg1  out  REG_ADDR_WIDTH  EX-stage destination.
- mem_wreg_en, mem_wmem_en  out  1 each  MEM-stage registered copies.
- mem_r1out, mem_r2out  out  DATA_WIDTH  MEM-stage operands.
- mem_wreg1  out  REG_ADDR_WIDTH  MEM-stage destination.
- mem_dout  out  DATA_WIDTH  port A read data.
- addrb  in  ADDR_WIDTH  port B address.
- dinb  in  DATA_WIDTH  port B write data.
- web  in  1  port B write enable.
- doutb  out  DATA_WIDTH  port B read data.

Behaviour:
- ID/EX register, every rising edge:
  - reset=1: all ex_* outputs become 0.
  - Otherwise each ex_* output takes its id_* input.
  - No stall, no enable.
- EX/MEM register: identical rule, mem_* outputs take ex_* values; reset clears all mem_* outputs to 0.
- Net delay: ID to MEM outputs is 2 cycles. An input presented before edge k appears on ex_* after edge k and on mem_* after edge k+1.
- Memory: 2^ADDR_WIDTH x DATA_WIDTH array with two independent synchronous ports on clk.
  - Initial contents are all zero.
  - The memory is NOT cleared by reset.
- Port A:
  - addra = mem_r1out[ADDR_WIDTH-1:0]; upper bits of mem_r1out are ignored, so addresses wrap modulo 256.
  - dina = mem_r2out; wea = mem_wmem_en.
  - Sampled at the rising edge; a store whose ID inputs arrive before edge k is written at edge k+2.
- Port B: addrb, dinb, web, sampled at the rising edge.
- Read latency is 1 cycle on both ports:
  - mem_dout and doutb update after the edge that samples the address.
  - Both are registered outputs, unaffected by reset, and hold their value between edges.
- Write mode is write-first on each port: on a write cycle, that port's dout returns the newly written data.
- Cross-port behaviour in the same cycle:
  - One port writes and the other port reads the same address: the reading port returns the old data; the new data is visible from the next read.
  - Both ports write the same address: port A's data is stored.
- Reset mid-operation:
  - Clears the pipeline registers only, so in-flight stores in ID/EX or EX/MEM are discarded (wmem_en forced to 0).
  - A store already presented to port A at the same edge as reset is still written.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold reset=1 for 2 edges with all id_* at nonzero values -> all ex_* and mem_* outputs are 0; memory contents unchanged.
- Pipeline latency: drive id_wreg_en=1, id_wreg1=5'd3, id_r1out=64'hA, id_r2out=64'hB for one cycle, then zeros -> ex_* shows those values after edge 1, mem_* after edge 2, and 0 after edge 3.
- Store then load via port A:
  - Present id_wmem_en=1, id_r1out=64'h0000_0000_0000_0110, id_r2out=64'hDEAD_BEEF_0123_4567, then id_wmem_en=0 with the same address.
  - Required: mem_dout = 64'hDEAD_BEEF_0123_4567, with address 0x10 used because bit 8 is ignored.
  - A port B read of addrb=8'h10 returns the same value.
- Host write / pipeline read: web=1, addrb=8'h05, dinb=64'h1122_3344_5566_7788 for one edge, then a pipeline read of address 5 -> mem_dout = 64'h1122_3344_5566_7788 two edges after the ID inputs.
- Cross-port collision, pre-load address 0x20 with 0:
  - Port A writes 64'hAAAA at 0x20 while port B reads 0x20 on the same edge: doutb = 0, and doutb = 64'hAAAA on the next read.
  - Both ports write 0x20 (A=64'h1, B=64'h2) on the same edge: a subsequent read gives 64'h1.
- Reset flush: issue a store to 0x30 of 64'h55, assert reset for one edge while the store sits in ID/EX -> address 0x30 remains 0.
